// File: rtl/riscv_lsu.sv
// Load/store unit: turns one core access into a handshaked memory transaction,
// aligning store data to byte lanes and extending load data by funct3.
module riscv_lsu #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [2:0]                req_funct,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   input  logic [4:0]                req_rd,
   output logic                      rsp_valid,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [4:0]                rsp_rd,
   output logic                      rsp_err,
   output logic                      rsp_misalign,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH/8-1:0]   mem_be,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic                      mem_gnt,
   input  logic                      mem_rvalid,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   input  logic                      mem_err,
   output logic [1:0]                o_dbg_state
);

   // Handshakes: a core access transfers on the cycle req_valid && req_ready;
   // a memory request transfers on mem_req && mem_gnt; the memory answers with
   // mem_rvalid only while in WAIT; rsp_valid is a one-cycle pulse with no
   // backpressure.

   localparam int NB   = DATA_WIDTH / 8;
   localparam int OFFW = $clog2(NB);
   localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TMO_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   state_t                  r_state;
   state_t                  w_state_nx;

   logic                    r_we;
   logic [2:0]              r_funct;
   logic [OFFW-1:0]         r_off;
   logic [4:0]              r_rd;
   logic [CW-1:0]           r_cnt;

   logic                    r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic [4:0]              r_rsp_rd;
   logic                    r_rsp_err;
   logic                    r_rsp_misalign;
   logic                    r_mem_req;
   logic                    r_mem_we;
   logic [ADDR_WIDTH-1:0]   r_mem_addr;
   logic [NB-1:0]           r_mem_be;
   logic [DATA_WIDTH-1:0]   r_mem_wdata;

   logic                    w_ready;
   logic                    w_accept;
   logic [1:0]              w_size;
   logic [OFFW-1:0]         w_off;
   logic                    w_illegal;
   logic                    w_misalign;
   logic                    w_tmo;
   logic [NB-1:0]           w_be;
   logic [DATA_WIDTH-1:0]   w_wdata_sh;
   logic [DATA_WIDTH-1:0]   w_ld_sh;
   logic [DATA_WIDTH-1:0]   w_ld_mask;
   logic                    w_ld_sign;
   logic [DATA_WIDTH-1:0]   w_ld_data;

   function automatic logic [NB-1:0] f_be(input logic [1:0] size);
      logic [NB-1:0] be;
      be = '0;
      for (int i = 0; i < NB; i++) be[i] = (i < (1 << size));
      return be;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] f_bits(input logic [NB-1:0] be);
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   assign w_ready  = (r_state == S_IDLE) && reset;
   assign w_accept = req_valid && w_ready;
   assign w_size   = req_funct[1:0];
   assign w_off    = req_addr[OFFW-1:0];
   assign w_tmo    = TMO_EN && (r_cnt == TMO_LAST);

   // Unsigned stores do not exist; D and WU need a 64-bit datapath.
   assign w_illegal = (req_funct == 3'b111) || (req_we && req_funct[2]) ||
                      ((DATA_WIDTH == 32) && ((req_funct == 3'b011) || (req_funct == 3'b110)));

   always_comb begin
      w_misalign = 1'b0;
      case (w_size)
         2'b01:   w_misalign = req_addr[0];
         2'b10:   w_misalign = |req_addr[1:0];
         2'b11:   w_misalign = |req_addr[2:0];
         default: w_misalign = 1'b0;
      endcase
   end

   assign w_be       = f_be(w_size) << w_off;
   assign w_wdata_sh = (req_wdata & f_bits(f_be(w_size))) << {w_off, 3'b000};

   assign w_ld_sh   = mem_rdata >> {r_off, 3'b000};
   assign w_ld_mask = f_bits(f_be(r_funct[1:0]));

   always_comb begin
      w_ld_sign = 1'b0;
      case (r_funct[1:0])
         2'b00:   w_ld_sign = w_ld_sh[7];
         2'b01:   w_ld_sign = w_ld_sh[15];
         2'b10:   w_ld_sign = w_ld_sh[31];
         default: w_ld_sign = w_ld_sh[DATA_WIDTH-1];
      endcase
   end

   assign w_ld_data = (w_ld_sh & w_ld_mask) |
                      ((w_ld_sign && !r_funct[2]) ? ~w_ld_mask : '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   // A response arriving in the same cycle as the timeout takes priority.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nx = (w_illegal || w_misalign) ? S_RESP : S_REQ;
         S_REQ: begin
            if (w_tmo)        w_state_nx = S_RESP;
            else if (mem_gnt) w_state_nx = S_WAIT;
         end
         S_WAIT: if (mem_rvalid || w_tmo) w_state_nx = S_RESP;
         S_RESP: w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we           <= 1'b0;
         r_funct        <= '0;
         r_off          <= '0;
         r_rd           <= '0;
         r_cnt          <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_rdata    <= '0;
         r_rsp_rd       <= '0;
         r_rsp_err      <= 1'b0;
         r_rsp_misalign <= 1'b0;
         r_mem_req      <= 1'b0;
         r_mem_we       <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_be       <= '0;
         r_mem_wdata    <= '0;
      end else begin
         r_rsp_valid <= (w_state_nx == S_RESP);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we    <= req_we;
                  r_funct <= req_funct;
                  r_off   <= w_off;
                  r_rd    <= req_rd;
                  r_cnt   <= '0;
                  if (w_illegal || w_misalign) begin
                     r_rsp_err      <= 1'b1;
                     r_rsp_misalign <= !w_illegal;
                     r_rsp_rdata    <= '0;
                     r_rsp_rd       <= req_rd;
                  end else begin
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= req_we;
                     r_mem_addr  <= req_addr & ~ADDR_WIDTH'(NB - 1);
                     r_mem_be    <= w_be;
                     r_mem_wdata <= w_wdata_sh;
                  end
               end
            end
            S_REQ: begin
               r_cnt <= r_cnt + CW'(1);
               if (w_tmo) begin
                  r_mem_req      <= 1'b0;
                  r_rsp_err      <= 1'b1;
                  r_rsp_misalign <= 1'b0;
                  r_rsp_rdata    <= '0;
                  r_rsp_rd       <= r_rd;
               end else if (mem_gnt) begin
                  r_mem_req <= 1'b0;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt + CW'(1);
               if (mem_rvalid) begin
                  r_rsp_err      <= mem_err;
                  r_rsp_misalign <= 1'b0;
                  r_rsp_rdata    <= (mem_err || r_we) ? '0 : w_ld_data;
                  r_rsp_rd       <= r_rd;
               end else if (w_tmo) begin
                  r_rsp_err      <= 1'b1;
                  r_rsp_misalign <= 1'b0;
                  r_rsp_rdata    <= '0;
                  r_rsp_rd       <= r_rd;
               end
            end
            S_RESP: begin
               r_rsp_err      <= 1'b0;
               r_rsp_misalign <= 1'b0;
               r_rsp_rdata    <= '0;
               r_rsp_rd       <= '0;
            end
            default: ;
         endcase
      end
   end

   assign req_ready    = w_ready;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_rdata    = r_rsp_rdata;
   assign rsp_rd       = r_rsp_rd;
   assign rsp_err      = r_rsp_err;
   assign rsp_misalign = r_rsp_misalign;
   assign mem_req      = r_mem_req;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_be       = r_mem_be;
   assign mem_wdata    = r_mem_wdata;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: a 32-bit instance (TIMEOUT=16) and a 64-bit
// instance (TIMEOUT=4) share one stimulus set, selected by sel64.
module tb_riscv_lsu;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic        sel64 = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct = '0;
   logic [31:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic        mem_err = 1'b0;
   logic [63:0] mem_rdata = '0;

   logic        a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_misalign, a_mem_req, a_mem_we;
   logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
   logic [4:0]  a_rsp_rd;
   logic [3:0]  a_mem_be;
   logic [1:0]  a_dbg_state;

   logic        b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_misalign, b_mem_req, b_mem_we;
   logic [63:0] b_rsp_rdata, b_mem_wdata;
   logic [31:0] b_mem_addr;
   logic [4:0]  b_rsp_rd;
   logic [7:0]  b_mem_be;
   logic [1:0]  b_dbg_state;

   riscv_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) u_dut32 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & ~sel64), .req_ready(a_req_ready), .req_we(req_we),
      .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_rd(a_rsp_rd),
      .rsp_err(a_rsp_err), .rsp_misalign(a_rsp_misalign),
      .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_be(a_mem_be),
      .mem_wdata(a_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata[31:0]), .mem_err(mem_err), .o_dbg_state(a_dbg_state)
   );

   riscv_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(4)) u_dut64 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid & sel64), .req_ready(b_req_ready), .req_we(req_we),
      .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_rd(b_rsp_rd),
      .rsp_err(b_rsp_err), .rsp_misalign(b_rsp_misalign),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
      .mem_wdata(b_mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .mem_err(mem_err), .o_dbg_state(b_dbg_state)
   );

   logic        ob_req_ready, ob_rsp_valid, ob_rsp_err, ob_rsp_misalign, ob_mem_req, ob_mem_we;
   logic [63:0] ob_rsp_rdata, ob_mem_wdata;
   logic [31:0] ob_mem_addr;
   logic [4:0]  ob_rsp_rd;
   logic [7:0]  ob_mem_be;

   assign ob_req_ready    = sel64 ? b_req_ready    : a_req_ready;
   assign ob_rsp_valid    = sel64 ? b_rsp_valid    : a_rsp_valid;
   assign ob_rsp_err      = sel64 ? b_rsp_err      : a_rsp_err;
   assign ob_rsp_misalign = sel64 ? b_rsp_misalign : a_rsp_misalign;
   assign ob_mem_req      = sel64 ? b_mem_req      : a_mem_req;
   assign ob_mem_we       = sel64 ? b_mem_we       : a_mem_we;
   assign ob_rsp_rdata    = sel64 ? b_rsp_rdata    : {32'h0, a_rsp_rdata};
   assign ob_mem_wdata    = sel64 ? b_mem_wdata    : {32'h0, a_mem_wdata};
   assign ob_mem_addr     = sel64 ? b_mem_addr     : a_mem_addr;
   assign ob_rsp_rd       = sel64 ? b_rsp_rd       : a_rsp_rd;
   assign ob_mem_be       = sel64 ? b_mem_be       : {4'h0, a_mem_be};

   // observations of the most recent access
   logic        o_ready, o_unstable, o_we, o_err, o_mis, o_memreq_rsp;
   int          o_nreq, o_npulse, o_lat;
   logic [31:0] o_addr;
   logic [7:0]  o_be;
   logic [63:0] o_wdata, o_rdata;
   logic [4:0]  o_rd;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One access; gnt_dly = mem_req cycles before grant, rv_dly = cycles from
   // grant to mem_rvalid (0 = never). Latency counts from the accept cycle.
   task automatic do_access(input bit use64, input bit we, input logic [2:0] funct,
                            input logic [31:0] addr, input logic [63:0] wdata,
                            input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                            input logic [63:0] rdata, input bit berr);
      int  gcnt;
      int  wcnt;
      int  c0;
      bit  granted;
      @(negedge clk);
      sel64 = use64;
      req_valid = 1'b1; req_we = we; req_funct = funct; req_addr = addr;
      req_wdata = wdata; req_rd = rd; mem_rdata = rdata;
      #1;
      o_ready = ob_req_ready;
      c0 = cyc;
      gcnt = 0; wcnt = 0; granted = 0;
      o_nreq = 0; o_npulse = 0; o_lat = -1; o_unstable = 0;
      o_we = 0; o_addr = '0; o_be = '0; o_wdata = '0;
      o_rdata = '0; o_err = 0; o_mis = 0; o_rd = '0; o_memreq_rsp = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
         if (ob_rsp_valid) begin
            o_npulse++;
            if (o_npulse == 1) begin
               o_lat = cyc - c0;
               o_rdata = ob_rsp_rdata; o_err = ob_rsp_err; o_mis = ob_rsp_misalign;
               o_rd = ob_rsp_rd; o_memreq_rsp = ob_mem_req;
            end
         end
         if (ob_mem_req && !granted) begin
            o_nreq++;
            if (o_nreq == 1) begin
               o_we = ob_mem_we; o_addr = ob_mem_addr; o_be = ob_mem_be; o_wdata = ob_mem_wdata;
            end else if ({ob_mem_we, ob_mem_addr, ob_mem_be, ob_mem_wdata} !== {o_we, o_addr, o_be, o_wdata}) begin
               o_unstable = 1;
            end
            if (gcnt >= gnt_dly) begin
               mem_gnt = 1'b1;
               granted = 1;
            end else begin
               gcnt++;
            end
         end else if (granted) begin
            wcnt++;
            if (wcnt == rv_dly) begin
               mem_rvalid = 1'b1;
               mem_err = berr;
            end
         end
      end
   endtask

   int pulses;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_a_ready", a_req_ready, 0);
      chk("rst_b_ready", b_req_ready, 0);
      chk("rst_a_rsp", {a_rsp_valid, a_rsp_err, a_rsp_misalign, a_mem_req, a_mem_we}, 0);
      chk("rst_a_bus", {a_mem_addr, a_mem_be, a_mem_wdata, a_rsp_rdata}, 0);
      chk("rst_b_bus", {b_mem_req, b_mem_be, b_mem_wdata}, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_a_ready", a_req_ready, 1);

      // LB / LBU at byte 3
      do_access(0, 0, 3'b000, 32'h103, 64'h0, 5'd5, 0, 1, 64'h80000000, 0);
      chk("lb_ready", o_ready, 1);
      chk("lb_addr", o_addr, 32'h100);
      chk("lb_be", o_be, 8'h08);
      chk("lb_we", o_we, 0);
      chk("lb_rdata", o_rdata, 64'hFFFFFF80);
      chk("lb_err", o_err, 0);
      chk("lb_rd", o_rd, 5);
      chk("lb_lat", o_lat, 3);
      chk("lb_pulses", o_npulse, 1);
      do_access(0, 0, 3'b100, 32'h103, 64'h0, 5'd6, 0, 1, 64'h80000000, 0);
      chk("lbu_rdata", o_rdata, 64'h80);

      // SH at upper half
      do_access(0, 1, 3'b001, 32'h202, 64'h1234ABCD, 5'd9, 0, 1, 64'hFFFFFFFF, 0);
      chk("sh_be", o_be, 8'h0C);
      chk("sh_wdata", o_wdata, 64'hABCD0000);
      chk("sh_we", o_we, 1);
      chk("sh_addr", o_addr, 32'h200);
      chk("sh_rdata", o_rdata, 0);
      chk("sh_err", o_err, 0);
      chk("sh_lat", o_lat, 3);

      // misaligned and illegal, no memory request
      do_access(0, 0, 3'b010, 32'h101, 64'h0, 5'd3, 0, 1, 64'h0, 0);
      chk("lw_mis_nreq", o_nreq, 0);
      chk("lw_mis_lat", o_lat, 1);
      chk("lw_mis_flags", {o_err, o_mis}, 2'b11);
      chk("lw_mis_rd", o_rd, 3);
      do_access(0, 0, 3'b011, 32'h100, 64'h0, 5'd4, 0, 1, 64'h0, 0);
      chk("ld32_nreq", o_nreq, 0);
      chk("ld32_flags", {o_err, o_mis}, 2'b10);
      do_access(0, 1, 3'b100, 32'h100, 64'h0, 5'd4, 0, 1, 64'h0, 0);
      chk("sbu_flags", {o_err, o_mis}, 2'b10);

      // delayed grant
      do_access(0, 0, 3'b010, 32'h300, 64'h0, 5'd11, 3, 2, 64'hDEADBEEF, 0);
      chk("dly_nreq", o_nreq, 4);
      chk("dly_stable", o_unstable, 0);
      chk("dly_pulses", o_npulse, 1);
      chk("dly_lat", o_lat, 7);
      chk("dly_rdata", o_rdata, 64'hDEADBEEF);

      // bus error
      do_access(0, 0, 3'b010, 32'h500, 64'h0, 5'd12, 0, 1, 64'h12345678, 1);
      chk("berr_flags", {o_err, o_mis}, 2'b10);
      chk("berr_rdata", o_rdata, 0);

      // timeout (TIMEOUT=4 instance): granted but no response, and never granted
      do_access(1, 0, 3'b010, 32'h10, 64'h0, 5'd13, 0, 0, 64'h0, 0);
      chk("tmo_wait_lat", o_lat, 5);
      chk("tmo_wait_err", {o_err, o_mis}, 2'b10);
      chk("tmo_wait_pulses", o_npulse, 1);
      do_access(1, 0, 3'b010, 32'h10, 64'h0, 5'd14, 99, 0, 64'h0, 0);
      chk("tmo_req_lat", o_lat, 5);
      chk("tmo_req_nreq", o_nreq, 4);
      chk("tmo_req_memreq", o_memreq_rsp, 0);
      chk("tmo_req_err", o_err, 1);

      // 64-bit lanes
      do_access(1, 0, 3'b110, 32'h804, 64'h0, 5'd15, 0, 1, 64'h80000001_00000000, 0);
      chk("lwu_be", o_be, 8'hF0);
      chk("lwu_addr", o_addr, 32'h800);
      chk("lwu_rdata", o_rdata, 64'h00000000_80000001);
      do_access(1, 0, 3'b010, 32'h804, 64'h0, 5'd16, 0, 1, 64'h80000001_00000000, 0);
      chk("lw64_rdata", o_rdata, 64'hFFFFFFFF_80000001);
      do_access(1, 0, 3'b001, 32'h806, 64'h0, 5'd17, 0, 1, 64'h8001_0000_0000_0000, 0);
      chk("lh64_rdata", o_rdata, 64'hFFFFFFFF_FFFF8001);
      chk("lh64_be", o_be, 8'hC0);
      do_access(1, 0, 3'b101, 32'h806, 64'h0, 5'd18, 0, 1, 64'h8001_0000_0000_0000, 0);
      chk("lhu64_rdata", o_rdata, 64'h8001);
      do_access(1, 1, 3'b000, 32'h805, 64'h1122_3344_5566_CDAB, 5'd19, 0, 1, 64'h0, 0);
      chk("sb64_be", o_be, 8'h20);
      chk("sb64_wdata", o_wdata, 64'h0000AB00_00000000);
      do_access(1, 1, 3'b011, 32'h808, 64'h01234567_89ABCDEF, 5'd20, 0, 1, 64'h0, 0);
      chk("sd_be", o_be, 8'hFF);
      chk("sd_wdata", o_wdata, 64'h01234567_89ABCDEF);
      chk("sd_addr", o_addr, 32'h808);
      do_access(1, 0, 3'b011, 32'h808, 64'h0, 5'd21, 0, 1, 64'h81234567_89ABCDEF, 0);
      chk("ld64_rdata", o_rdata, 64'h81234567_89ABCDEF);
      do_access(1, 0, 3'b011, 32'h804, 64'h0, 5'd22, 0, 1, 64'h0, 0);
      chk("ld64_mis_flags", {o_err, o_mis}, 2'b11);
      chk("ld64_mis_nreq", o_nreq, 0);
      do_access(1, 0, 3'b111, 32'h800, 64'h0, 5'd23, 0, 1, 64'h0, 0);
      chk("f111_flags", {o_err, o_mis}, 2'b10);

      // reset while in WAIT, then a late mem_rvalid
      @(negedge clk);
      sel64 = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_funct = 3'b010; req_addr = 32'h400; req_rd = 5'd7;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rw_memreq", a_mem_req, 1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("rw_in_wait", a_dbg_state, 2);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rw_rst_ready", a_req_ready, 0);
      chk("rw_rst_ctl", {a_rsp_valid, a_rsp_err, a_mem_req, a_mem_we, a_dbg_state}, 0);
      chk("rw_rst_bus", {a_mem_addr, a_mem_be, a_mem_wdata, a_rsp_rdata, a_rsp_rd}, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 64'hCAFEF00D;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (a_rsp_valid) pulses++;
      end
      chk("rw_no_rsp", pulses, 0);
      chk("rw_idle_ready", a_req_ready, 1);
      chk("rw_idle_out", {a_mem_req, a_rsp_rdata, a_rsp_err}, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
